// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency memory between the instruction
// fetch stage (I) and the data stage (D). Requests are held levels. Only one
// access is in flight at a time. D has priority, but a starvation counter
// forces an I grant once STARVE_MAX consecutive D grants have been made while
// I was waiting. Each access produces a one-cycle done pulse and registered
// read data. The stall outputs feed the enable-gated pipeline registers.
//
// Parameters
//   LATENCY    : cycles from the mem_en cycle to the rdata-valid cycle,
//                inclusive (1..15)
//   STARVE_MAX : consecutive D grants allowed while i_req pends (1..7)
//
// Ports
//   clk, rst                       : clock, asynchronous active-low reset
//   i_req, i_addr                  : fetch request (held until i_done)
//   d_req, d_wr, d_addr, d_wdata   : data request (held until d_done)
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                      : registered memory command
//   mem_rdata                      : memory read data, valid when cnt == 0
//   i_done, i_rdata                : fetch completion pulse and data
//   d_done, d_rdata                : data completion pulse and load data
//   i_stall, d_stall               : combinational stalls for the pipeline
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LATENCY    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        i_stall,
  output logic        d_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  // Owner encoding: 0 = fetch, 1 = data.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  starve_q, starve_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic arb_phase;
  logic i_elig;
  logic d_elig;
  logic starve_hit;
  logic grant_i;
  logic grant_d;
  logic last_beat;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration and next state
  // -------------------------------------------------------------------------
  always_comb begin
    arb_phase = (state_q == IDLE) || (state_q == DONE);
    // In DONE the requester just served still has its request up for this
    // cycle; that level belongs to the finished access, so it is masked.
    i_elig     = i_req && !((state_q == DONE) && (owner_q == OWN_I));
    d_elig     = d_req && !((state_q == DONE) && (owner_q == OWN_D));
    starve_hit = (starve_q == STARVE_LIM) && i_elig;
    grant_d    = arb_phase && d_elig && !starve_hit;
    grant_i    = arb_phase && i_elig && !grant_d;
    last_beat  = (state_q == BUSY) && (cnt_q == 4'd0);

    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = (grant_i || grant_d) ? BUSY : IDLE;
      BUSY:       state_d = last_beat ? DONE : BUSY;
      default:    state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    // The strobe is registered from the grant, so it is high exactly in the
    // first BUSY cycle.
    mem_en_d = grant_i || grant_d;
    i_done_d = last_beat && (owner_q == OWN_I);
    d_done_d = last_beat && (owner_q == OWN_D);

    if (grant_d) begin
      owner_d     = OWN_D;
      cnt_d       = CNT_INIT;
      mem_wr_d    = d_wr;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      if (i_req && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + 3'd1;
      end
    end else if (grant_i) begin
      owner_d     = OWN_I;
      cnt_d       = CNT_INIT;
      mem_wr_d    = 1'b0;
      mem_addr_d  = i_addr;
      mem_wdata_d = '0;
      starve_d    = '0;
    end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    // Writes leave the read-data registers untouched.
    if (last_beat && !mem_wr_q) begin
      if (owner_q == OWN_I) begin
        i_rdata_d = mem_rdata;
      end else begin
        d_rdata_d = mem_rdata;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two instances: dut0 with LATENCY=4 / STARVE_MAX=3, dut1 with LATENCY=1.
// Directed stimulus pushes expected memory commands and done pulses (with
// their absolute cycle numbers) into queues; monitor processes pop and
// compare whenever a DUT raises mem_en, i_done or d_done.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT0 = 4;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // dut0 signals
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr, i_done, d_done, i_stall, d_stall;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, i_rdata, d_rdata;

  // dut1 signals
  logic        i_req1, d_req1, d_wr1;
  logic [15:0] i_addr1, d_addr1, d_wdata1;
  logic        mem_en1, mem_wr1, i_done1, d_done1, i_stall1, d_stall1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1, i_rdata1, d_rdata1;

  mem_exp_t  mq0[$];
  done_exp_t iq0[$];
  done_exp_t dq0[$];
  mem_exp_t  mq1[$];
  done_exp_t iq1[$];
  done_exp_t dq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.LATENCY(LAT0), .STARVE_MAX(3)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .i_done(i_done), .i_rdata(i_rdata), .d_done(d_done), .d_rdata(d_rdata),
    .i_stall(i_stall), .d_stall(d_stall)
  );

  mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(3)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1),
    .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1),
    .i_done(i_done1), .i_rdata(i_rdata1), .d_done(d_done1), .d_rdata(d_rdata1),
    .i_stall(i_stall1), .d_stall(d_stall1)
  );

  // Memory contents as a pure function of address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory model for dut0: data appears only in the cycle LAT0-1 after
  // mem_en; any other cycle carries a poison value.
  logic [15:0] m0_addr = '0;
  int          m0_rem  = 0;
  logic        m0_pend = 1'b0;
  initial mem_rdata = 16'hDEAD;
  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      m0_pend = 1'b1;
      m0_rem  = LAT0 - 1;
      m0_addr = mem_addr;
    end else if (m0_pend) begin
      if (m0_rem == 0) m0_pend = 1'b0;
      else m0_rem = m0_rem - 1;
    end
    mem_rdata = (m0_pend && m0_rem == 0) ? mem_fn(m0_addr) : 16'hDEAD;
  end

  // LATENCY=1 memory: data valid in the mem_en cycle itself.
  assign mem_rdata1 = mem_en1 ? mem_fn(mem_addr1) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitors
  always @(negedge clk) begin
    mem_exp_t  me;
    done_exp_t de;
    if (mem_en) begin
      if (mq0.size() == 0) unexpected("mem0");
      else begin
        me = mq0.pop_front();
        $display("dut0 mem_en  cyc=%0d addr=%h wr=%0b wdata=%h", cyc, mem_addr, mem_wr, mem_wdata);
        chk("mem0_cyc", cyc, me.cyc);
        chk("mem0_addr", {16'h0, mem_addr}, {16'h0, me.addr});
        chk("mem0_wr", {31'h0, mem_wr}, {31'h0, me.wr});
        if (me.wr) chk("mem0_wdata", {16'h0, mem_wdata}, {16'h0, me.wdata});
      end
    end
    if (i_done) begin
      if (iq0.size() == 0) unexpected("i_done0");
      else begin
        de = iq0.pop_front();
        $display("dut0 i_done  cyc=%0d i_rdata=%h", cyc, i_rdata);
        chk("i_done0_cyc", cyc, de.cyc);
        chk("i_rdata0", {16'h0, i_rdata}, {16'h0, de.data});
      end
    end
    if (d_done) begin
      if (dq0.size() == 0) unexpected("d_done0");
      else begin
        de = dq0.pop_front();
        $display("dut0 d_done  cyc=%0d d_rdata=%h", cyc, d_rdata);
        chk("d_done0_cyc", cyc, de.cyc);
        chk("d_rdata0", {16'h0, d_rdata}, {16'h0, de.data});
      end
    end
  end

  always @(negedge clk) begin
    mem_exp_t  me;
    done_exp_t de;
    if (mem_en1) begin
      if (mq1.size() == 0) unexpected("mem1");
      else begin
        me = mq1.pop_front();
        $display("dut1 mem_en  cyc=%0d addr=%h wr=%0b", cyc, mem_addr1, mem_wr1);
        chk("mem1_cyc", cyc, me.cyc);
        chk("mem1_addr", {16'h0, mem_addr1}, {16'h0, me.addr});
        chk("mem1_wr", {31'h0, mem_wr1}, {31'h0, me.wr});
      end
    end
    if (i_done1) begin
      if (iq1.size() == 0) unexpected("i_done1");
      else begin
        de = iq1.pop_front();
        $display("dut1 i_done  cyc=%0d i_rdata=%h", cyc, i_rdata1);
        chk("i_done1_cyc", cyc, de.cyc);
        chk("i_rdata1", {16'h0, i_rdata1}, {16'h0, de.data});
      end
    end
    if (d_done1) begin
      if (dq1.size() == 0) unexpected("d_done1");
      else begin
        de = dq1.pop_front();
        $display("dut1 d_done  cyc=%0d d_rdata=%h", cyc, d_rdata1);
        chk("d_done1_cyc", cyc, de.cyc);
        chk("d_rdata1", {16'h0, d_rdata1}, {16'h0, de.data});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"},    {31'h0, mem_en},    32'h0);
    chk({tag, "_mem_wr"},    {31'h0, mem_wr},    32'h0);
    chk({tag, "_mem_addr"},  {16'h0, mem_addr},  32'h0);
    chk({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
    chk({tag, "_i_rdata"},   {16'h0, i_rdata},   32'h0);
    chk({tag, "_d_rdata"},   {16'h0, d_rdata},   32'h0);
    chk({tag, "_i_done"},    {31'h0, i_done},    32'h0);
    chk({tag, "_d_done"},    {31'h0, d_done},    32'h0);
  endtask

  initial begin
    int t0;
    rst = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    i_req1 = 0; d_req1 = 0; d_wr1 = 0; i_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;

    // Reset state
    tick(2);
    check_all_zero("reset");
    chk("reset_i_stall", {31'h0, i_stall}, 32'h0);
    rst = 1'b1;
    tick(2);

    // Single fetch: mem_en cycle 1, i_done cycle 5, stall cycles 0-4
    t0 = cyc;
    i_addr = 16'h0010; i_req = 1'b1;
    mq0.push_back('{t0 + 1, 16'h0010, 1'b0, 16'h0});
    iq0.push_back('{t0 + 5, 16'hBEEF});
    for (int k = 0; k < 5; k++) begin
      #1 chk("fetch_i_stall_hi", {31'h0, i_stall}, 32'h1);
      tick(1);
    end
    #1 chk("fetch_i_stall_done", {31'h0, i_stall}, 32'h0);
    tick(1);
    i_req = 1'b0;
    tick(2);

    // Simultaneous requests: D first, then I granted in the D DONE cycle
    t0 = cyc;
    d_addr = 16'h0200; d_wr = 1'b0; d_req = 1'b1;
    i_addr = 16'h0020; i_req = 1'b1;
    mq0.push_back('{t0 + 1, 16'h0200, 1'b0, 16'h0});
    dq0.push_back('{t0 + 5, mem_fn(16'h0200)});
    mq0.push_back('{t0 + 6, 16'h0020, 1'b0, 16'h0});
    iq0.push_back('{t0 + 10, mem_fn(16'h0020)});
    tick(6);
    d_req = 1'b0;
    tick(5);
    i_req = 1'b0;
    tick(2);

    // Data write: d_rdata keeps the previous load value
    t0 = cyc;
    d_addr = 16'h0300; d_wdata = 16'h1234; d_wr = 1'b1; d_req = 1'b1;
    mq0.push_back('{t0 + 1, 16'h0300, 1'b1, 16'h1234});
    dq0.push_back('{t0 + 5, mem_fn(16'h0200)});
    #1 chk("write_d_stall", {31'h0, d_stall}, 32'h1);
    tick(6);
    d_req = 1'b0; d_wr = 1'b0;
    tick(2);

    // Starvation guard: three D grants made while i_req is up (i_req is
    // withdrawn after each grant cycle so the DONE cycles do not serve I),
    // then with both requesting the guard must pick I.
    t0 = cyc;
    i_addr = 16'h0040; d_addr = 16'h0500; d_req = 1'b1; i_req = 1'b1;
    mq0.push_back('{t0 + 1, 16'h0500, 1'b0, 16'h0});
    dq0.push_back('{t0 + 5, mem_fn(16'h0500)});
    tick(1); i_req = 1'b0;
    tick(5);
    d_addr = 16'h0510; i_req = 1'b1;
    mq0.push_back('{t0 + 7, 16'h0510, 1'b0, 16'h0});
    dq0.push_back('{t0 + 11, mem_fn(16'h0510)});
    tick(1); i_req = 1'b0;
    tick(5);
    d_addr = 16'h0520; i_req = 1'b1;
    mq0.push_back('{t0 + 13, 16'h0520, 1'b0, 16'h0});
    dq0.push_back('{t0 + 17, mem_fn(16'h0520)});
    tick(1); i_req = 1'b0;
    tick(5);
    d_addr = 16'h0530; i_req = 1'b1;
    mq0.push_back('{t0 + 19, 16'h0040, 1'b0, 16'h0});
    iq0.push_back('{t0 + 23, mem_fn(16'h0040)});
    mq0.push_back('{t0 + 24, 16'h0530, 1'b0, 16'h0});
    dq0.push_back('{t0 + 28, mem_fn(16'h0530)});
    tick(6);
    i_req = 1'b0;
    tick(5);
    d_req = 1'b0;
    tick(2);

    // Asynchronous reset in cycle 2 of a fetch, then a fresh access
    t0 = cyc;
    i_addr = 16'h0050; i_req = 1'b1;
    mq0.push_back('{t0 + 1, 16'h0050, 1'b0, 16'h0});
    tick(2);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    chk("midrst_i_stall", {31'h0, i_stall}, 32'h1);
    chk("midrst_d_stall", {31'h0, d_stall}, 32'h0);
    tick(1);
    rst = 1'b1;
    mq0.push_back('{t0 + 4, 16'h0050, 1'b0, 16'h0});
    iq0.push_back('{t0 + 8, mem_fn(16'h0050)});
    tick(6);
    i_req = 1'b0;
    tick(2);

    // LATENCY=1: alternating D / I, one access every two cycles
    t0 = cyc;
    d_addr1 = 16'h0400; d_req1 = 1'b1;
    mq1.push_back('{t0 + 1, 16'h0400, 1'b0, 16'h0});
    dq1.push_back('{t0 + 2, mem_fn(16'h0400)});
    mq1.push_back('{t0 + 3, 16'h0410, 1'b0, 16'h0});
    iq1.push_back('{t0 + 4, mem_fn(16'h0410)});
    mq1.push_back('{t0 + 5, 16'h0420, 1'b0, 16'h0});
    dq1.push_back('{t0 + 6, mem_fn(16'h0420)});
    mq1.push_back('{t0 + 7, 16'h0430, 1'b0, 16'h0});
    iq1.push_back('{t0 + 8, mem_fn(16'h0430)});
    tick(1); i_addr1 = 16'h0410; i_req1 = 1'b1;
    tick(2); d_addr1 = 16'h0420;
    tick(2); i_addr1 = 16'h0430;
    tick(2); d_req1 = 1'b0;
    tick(2); i_req1 = 1'b0;
    tick(3);

    // Every expected event must have been seen
    chk("mem0_left", mq0.size(), 32'h0);
    chk("i_done0_left", iq0.size(), 32'h0);
    chk("d_done0_left", dq0.size(), 32'h0);
    chk("mem1_left", mq1.size(), 32'h0);
    chk("i_done1_left", iq1.size(), 32'h0);
    chk("d_done1_left", dq1.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
